// File: rtl/gpio_in_reg.sv
// GPIO input register block: two-flop synchronizer, per-bit debounce, sticky edge
// flags with write-1-to-clear, and a level interrupt on a simple register bus.
module gpio_in_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       addr,
  input  logic [7:0]       wdata,
  input  logic             we,
  output logic [7:0]       rdata_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  localparam int unsigned    CW       = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [3:0] ADDR_DATA    = 4'h0;
  localparam logic [3:0] ADDR_RISE_EN = 4'h1;
  localparam logic [3:0] ADDR_FALL_EN = 4'h2;
  localparam logic [3:0] ADDR_STATUS  = 4'h3;
  localparam logic [3:0] ADDR_RAW     = 4'h4;

  logic [WIDTH-1:0]         sync1;
  logic [WIDTH-1:0]         sync2;
  logic [WIDTH-1:0]         stable;
  logic [WIDTH-1:0]         rise_en;
  logic [WIDTH-1:0]         fall_en;
  logic [WIDTH-1:0]         status;
  logic [WIDTH-1:0][CW-1:0] cnt;

  logic [WIDTH-1:0]         stable_nxt;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt;
  logic [WIDTH-1:0]         rise;
  logic [WIDTH-1:0]         fall;
  logic [WIDTH-1:0]         set_bits;
  logic [WIDTH-1:0]         clr_bits;
  logic                     wr_rise_en;
  logic                     wr_fall_en;

  // Debounce: accept sync2 only after DB_CYCLES consecutive disagreeing samples
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    rise       = '0;
    fall       = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
          rise[i]       = sync2[i];
          fall[i]       = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign wr_rise_en = we && (addr == ADDR_RISE_EN);
  assign wr_fall_en = we && (addr == ADDR_FALL_EN);
  assign clr_bits   = (we && (addr == ADDR_STATUS)) ? wdata[WIDTH-1:0] : '0;
  assign set_bits   = (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      cnt     <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
    end else begin
      sync1  <= gpio_in;
      sync2  <= sync1;
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
      // A set in the same cycle as its clear takes priority
      status <= (status & ~clr_bits) | set_bits;
      if (wr_rise_en) rise_en <= wdata[WIDTH-1:0];
      if (wr_fall_en) fall_en <= wdata[WIDTH-1:0];
    end
  end

  assign irq = |status;

  always_comb begin
    rdata_out = '0;
    case (addr)
      ADDR_DATA:    rdata_out = 8'(stable);
      ADDR_RISE_EN: rdata_out = 8'(rise_en);
      ADDR_FALL_EN: rdata_out = 8'(fall_en);
      ADDR_STATUS:  rdata_out = 8'(status);
      ADDR_RAW:     rdata_out = 8'(sync2);
      default:      rdata_out = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_in_reg.sv
// Bench for gpio_in_reg: directed corner sequences, a register-decode vector table,
// and randomized traffic checked every cycle against a sample-window reference model.
module tb_gpio_in_reg;
  localparam int unsigned W  = 8;
  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata_out;
  logic [7:0] gpio_in;
  logic       irq;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: pin delay line, last DB synchronized samples, registers
  logic [7:0] m_s1, m_s2, m_stable, m_re, m_fe, m_st;
  logic [7:0] m_hist [DB];

  typedef struct {
    logic [3:0] a;
    logic [7:0] wd;
    logic       w;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [$];

  gpio_in_reg #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata_out (rdata_out),
    .gpio_in   (gpio_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    case (a)
      4'h0:    return m_stable;
      4'h1:    return m_re;
      4'h2:    return m_fe;
      4'h3:    return m_st;
      4'h4:    return m_s2;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_re = '0; m_fe = '0; m_st = '0;
    for (int k = 0; k < int'(DB); k++) m_hist[k] = '0;
  endtask

  // A bit flips when the last DB synchronized samples all disagree with it
  task automatic model_clock(input logic [3:0] a, input logic [7:0] wd, input logic w,
                             input logic [7:0] pins);
    logic [7:0] nxt, rise, fall, setv, clr;
    logic       dis;
    for (int k = int'(DB) - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_s2;
    nxt = m_stable;
    for (int b = 0; b < 8; b++) begin
      dis = 1'b1;
      for (int k = 0; k < int'(DB); k++)
        if (m_hist[k][b] == m_stable[b]) dis = 1'b0;
      if (dis) nxt[b] = ~m_stable[b];
    end
    rise = nxt & ~m_stable;
    fall = ~nxt & m_stable;
    setv = (rise & m_re) | (fall & m_fe);
    clr  = (w && a == 4'h3) ? wd : 8'h00;
    m_st = (m_st & ~clr) | setv;
    if (w && a == 4'h1) m_re = wd;
    if (w && a == 4'h2) m_fe = wd;
    m_stable = nxt;
    m_s2 = m_s1;
    m_s1 = pins;
  endtask

  task automatic cyc(input logic [3:0] a, input logic [7:0] wd, input logic w,
                     input logic [7:0] pins, input string tag);
    addr = a; wdata = wd; we = w; gpio_in = pins;
    model_clock(a, wd, w, pins);
    @(posedge clk);
    #1;
    chk({tag, "_rd"}, rdata_out, exp_rd(a));
    chk({tag, "_irq"}, {7'b0, irq}, {7'b0, |m_st});
  endtask

  task automatic rd_expect(input logic [3:0] a, input logic [7:0] exp, input string tag);
    we = 1'b0; addr = a;
    #1;
    chk(tag, rdata_out, exp);
  endtask

  task automatic add_vec(input logic [3:0] a, input logic [7:0] wd, input logic w,
                         input logic [7:0] exp);
    vec_t v;
    v.a = a; v.wd = wd; v.w = w; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] pins;
    logic [3:0] ra;
    logic       rw;

    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; gpio_in = 8'hFF;
    model_reset();

    // Reset state with pins high
    @(posedge clk); #1;
    for (int a = 0; a < 5; a++) rd_expect(4'(a), 8'h00, "rst_state");
    chk("rst_irq", {7'b0, irq}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pins held high through reset release are accepted as a normal rise
    repeat (5) cyc(4'h0, 8'h00, 1'b0, 8'hFF, "t1");
    rd_expect(4'h0, 8'h00, "t1_data_e4");
    cyc(4'h0, 8'h00, 1'b0, 8'hFF, "t1");
    rd_expect(4'h0, 8'hFF, "t1_data_e5");
    rd_expect(4'h3, 8'h00, "t1_status");
    chk("t1_irq", {7'b0, irq}, 8'h00);

    // Rising edge on bit 0 with RISE_EN[0], then W1C
    repeat (7) cyc(4'h0, 8'h00, 1'b0, 8'hFE, "t2_pre");
    cyc(4'h1, 8'h01, 1'b1, 8'hFE, "t2_wen");
    repeat (5) cyc(4'h3, 8'h00, 1'b0, 8'hFF, "t2");
    rd_expect(4'h3, 8'h00, "t2_status_e4");
    cyc(4'h3, 8'h00, 1'b0, 8'hFF, "t2");
    rd_expect(4'h3, 8'h01, "t2_status_e5");
    rd_expect(4'h0, 8'hFF, "t2_data");
    chk("t2_irq_set", {7'b0, irq}, 8'h01);
    cyc(4'h3, 8'h01, 1'b1, 8'hFF, "t2_w1c");
    rd_expect(4'h3, 8'h00, "t2_status_clr");
    chk("t2_irq_clr", {7'b0, irq}, 8'h00);

    // Bounce on bit 1: high 3, low 1, high 6
    repeat (7) cyc(4'h0, 8'h00, 1'b0, 8'hFD, "t3_pre");
    cyc(4'h1, 8'h02, 1'b1, 8'hFD, "t3_ren");
    cyc(4'h2, 8'h02, 1'b1, 8'hFD, "t3_fen");
    repeat (3) cyc(4'h4, 8'h00, 1'b0, 8'hFF, "t3_raw");
    cyc(4'h4, 8'h00, 1'b0, 8'hFD, "t3_raw");
    repeat (3) cyc(4'h4, 8'h00, 1'b0, 8'hFF, "t3_raw");
    rd_expect(4'h0, 8'hFD, "t3_data_bounce");
    repeat (3) cyc(4'h4, 8'h00, 1'b0, 8'hFF, "t3_raw");
    repeat (4) cyc(4'h0, 8'h00, 1'b0, 8'hFF, "t3");
    rd_expect(4'h0, 8'hFF, "t3_data");
    rd_expect(4'h3, 8'h02, "t3_status");
    cyc(4'h3, 8'h02, 1'b1, 8'hFF, "t3_w1c");
    rd_expect(4'h3, 8'h00, "t3_status_clr");

    // Fall on bit 2 coincides with W1C of the same bit: set wins
    cyc(4'h2, 8'h06, 1'b1, 8'hFF, "t4_fen");
    repeat (5) cyc(4'h0, 8'h00, 1'b0, 8'hFB, "t4");
    cyc(4'h3, 8'h04, 1'b1, 8'hFB, "t4_setclr");
    rd_expect(4'h3, 8'h04, "t4_status");
    rd_expect(4'h0, 8'hFB, "t4_data");
    chk("t4_irq", {7'b0, irq}, 8'h01);

    // Async reset mid-debounce with STATUS=0x05
    cyc(4'h2, 8'h07, 1'b1, 8'hFB, "t5_fen");
    repeat (6) cyc(4'h0, 8'h00, 1'b0, 8'hFA, "t5");
    rd_expect(4'h3, 8'h05, "t5_status");
    repeat (4) cyc(4'h0, 8'h00, 1'b0, 8'hF2, "t5_cnt");
    rst = 1'b1;
    model_reset();
    for (int a = 0; a < 5; a++) rd_expect(4'(a), 8'h00, "t5_rst");
    chk("t5_rst_irq", {7'b0, irq}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) cyc(4'h0, 8'h00, 1'b0, 8'hF2, "t5_re");
    rd_expect(4'h0, 8'h00, "t5_restart_e4");
    cyc(4'h0, 8'h00, 1'b0, 8'hF2, "t5_re");
    rd_expect(4'h0, 8'hF2, "t5_restart_e5");
    rd_expect(4'h3, 8'h00, "t5_status_after");

    // Register decode vectors
    add_vec(4'h0, 8'hAA, 1'b1, 8'hF2);
    add_vec(4'h4, 8'hAA, 1'b1, 8'hF2);
    add_vec(4'h9, 8'hAA, 1'b1, 8'h00);
    for (int a = 5; a < 16; a++) add_vec(4'(a), 8'h00, 1'b0, 8'h00);
    add_vec(4'h1, 8'h3C, 1'b1, 8'h3C);
    add_vec(4'h0, 8'h00, 1'b0, 8'hF2);
    add_vec(4'h2, 8'h00, 1'b0, 8'h00);
    add_vec(4'h3, 8'h00, 1'b0, 8'h00);
    add_vec(4'h1, 8'h00, 1'b0, 8'h3C);
    foreach (tbl[i]) begin
      cyc(tbl[i].a, tbl[i].wd, tbl[i].w, 8'hF2, "t6");
      chk("t6_tbl", rdata_out, tbl[i].exp);
    end

    // Randomized traffic: slowly toggling pins with random bus accesses
    pins = 8'hF2;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
      ra = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      rw = ($urandom_range(0, 2) == 0);
      cyc(ra, 8'($urandom), rw, pins, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_in_reg.md
Name: gpio_in_reg

Overview:
Input-direction companion to the GPIO output register: samples WIDTH external pins, synchronizes and debounces them, and exposes level and edge-event state on the same simple register bus (addr/wdata/we, combinational rdata_out). Sticky per-bit edge flags with write-1-to-clear semantics drive a single level interrupt to the system controller.

Parameters:
WIDTH, 8, number of input pins; bus data width is fixed at 8, and WIDTH must be <= 8.
DB_CYCLES, 4, debounce length in clk cycles; must be >= 1. The per-bit counter width is clog2(DB_CYCLES)+1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
addr  input  4  register address
wdata  input  8  write data
we  input  1  write strobe, sampled on rising clk edge
rdata_out  output  8  combinational read data for addr
gpio_in  input  WIDTH  asynchronous external pins
irq  output  1  level interrupt = OR of all STATUS bits

Behaviour:
- Reset (async, rst=1): sync1, sync2, stable, counters, RISE_EN, FALL_EN and STATUS are all 0. So irq=0 and rdata_out=0 at every address while in reset. Reset mid-debounce discards the partial count. After release, a pin held high is accepted as a normal 0->1 transition, but it sets STATUS only if RISE_EN has been written first.
- Synchronizer: two flops per bit, gpio_in -> sync1 -> sync2. No reset-value glitch filtering beyond the debounce stage.
- Debounce, per bit i, evaluated every cycle:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: stable[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any bounce back to the stable value restarts the count.
  - Latency: a pin change meeting setup before edge E0 appears in stable at edge E(1+DB_CYCLES). The default is 5 cycles.
- Edge detect is the same cycle as the stable update:
  - rise[i] = stable update 0->1.
  - fall[i] = stable update 1->0.
  - set[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- STATUS update: STATUS <= (STATUS & ~clr) | set.
  - clr = wdata[WIDTH-1:0] when we=1 and addr=0x3, else 0.
  - If set and clear hit the same bit in the same cycle, set wins.
  - A write of 0 has no effect.
- irq = |STATUS, combinational from the STATUS flops, so it is glitch-free. It deasserts the cycle after the W1C write edge.
- Register map (full 4-bit decode; unmapped addresses read 0 and ignore writes; bits above WIDTH read 0):
  - 0x0 DATA (RO): stable.
  - 0x1 RISE_EN (RW).
  - 0x2 FALL_EN (RW).
  - 0x3 STATUS (R/W1C).
  - 0x4 RAW (RO): sync2, undebounced, for diagnostics.
  - Writes to 0x0 and 0x4 are ignored.
- Enable writes take effect for edges detected on the cycle after the write edge. Clearing an enable does not clear existing STATUS bits.
- Read path: rdata_out is a purely combinational mux of addr and the register flops. Reads have no side effects.

Test Plan:
1. Reset with gpio_in=0xFF held -> after release: DATA=0x00 through edge 4, DATA=0xFF at edge 5 (DB_CYCLES=4); STATUS=0x00 and irq=0 because the enables are 0.
2. Write RISE_EN=0x01, drive gpio_in[0] 0->1 -> at edge 5, DATA[0]=1, STATUS=0x01, irq=1. Write 0x01 to 0x3 -> STATUS=0x00 and irq=0 the next cycle.
3. Bounce: gpio_in[1] high for 3 cycles, low 1 cycle, high for 6 cycles, with FALL_EN=RISE_EN=0x02 -> DATA[1] rises only after 4 consecutive high samples; exactly one STATUS[1] set; RAW[1] follows every toggle 2 cycles late.
4. Simultaneous set and clear: arrange stable[2] to fall on the same edge as a W1C write of 0x04 to 0x3 with FALL_EN[2]=1 -> STATUS[2]=1 after that edge and irq stays 1.
5. Assert rst for 1 cycle mid-debounce (count=2) with STATUS=0x05 -> all registers read 0 and irq=0 immediately (async). Debounce then restarts from count 0.
6. Bus decode: write 0xAA to 0x0, 0x4 and 0x9 -> no state changes; reads of 0x5–0xF return 0x00. Write 0x3C to 0x1 -> reads back 0x3C.
